uart_rx_multi: RTL and testbench
================================

# uart_rx_multi

Parametrised UART receiver: configurable data width, parity and stop bits, 16x oversampled majority-vote sampling, false-start rejection, and framing/parity/break/overrun error reporting. Received words go into a small show-ahead FIFO read through a valid/ready handshake. Sits between the sensor serial pin (GY_MCU90640 link) and the frame-assembly logic.

## Interface
- CLK_FREQ, 50000000: system clock frequency in Hz.
- UART_BPS, 115200: baud rate.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries, power of 2, ≥2.
- clk_50m  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- uart_rxd  in  1  serial input, asynchronous, idle high.
- rx_data  out  DATA_BITS  FIFO head data word.
- rx_perr  out  1  parity error flag stored with the head word.
- rx_ferr  out  1  framing error flag stored with the head word.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head word when rx_valid & rx_ready.
- rx_break  out  1  one-cycle pulse on break detection.
- rx_overrun  out  1  sticky; set when a frame is dropped on a full FIFO; cleared only by rst.

## Operation
- Input synchroniser: two flops. Both reset to 1 so reset never produces a false start.
- Oversample tick: DIV = CLK_FREQ/(UART_BPS*16), integer truncation (27 at defaults). Counter width is $clog2(DIV). Tick is active 1 cycle in DIV. The counter restarts at 0 on the falling edge detected in IDLE.
- Bit timing: a 4-bit sample counter counts 16 ticks per bit. The bit value is the majority of samples 7, 8 and 9.
- FSM states:
  - IDLE: on synced falling edge, go to START.
  - START: at the bit decision, a majority of 1 is a false start; return to IDLE with no output. A 0 goes to DATA.
  - DATA: shift DATA_BITS bits, LSB first. After the last bit, go to PARITY if PARITY≠0, else STOP.
  - PARITY: perr = received bit ≠ expected bit. Odd parity expects the XOR of data and parity to be 1; even expects 0.
  - STOP: each stop bit is decided at its mid-bit majority, with no wait for the bit end.
    - Any stop bit of 0 sets ferr.
    - All data bits 0 and the first stop bit 0 means a break: pulse rx_break, write nothing, go to BREAK.
    - Otherwise commit the word on the final stop decision and return to IDLE.
  - BREAK: wait for a synced 1, then go to IDLE.
- Commit writes {ferr, perr, data} to the FIFO. If the FIFO is full, the word is dropped and rx_overrun is set.
- FIFO: show-ahead, so outputs reflect the head entry combinationally from storage.
  - Pop when rx_valid & rx_ready.
  - Simultaneous push and pop is allowed when full: the pop frees the slot, the push succeeds, and there is no overrun.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.

## Timing
- Reset values: rx_data=0, rx_perr=0, rx_ferr=0, rx_valid=0, rx_break=0, rx_overrun=0. FSM goes to IDLE, FIFO is emptied, tick counter is 0.
- Synchroniser latency is 2 cycles from the pin to the FSM.
- FIFO write happens on the cycle after the final stop-bit decision. rx_valid rises on the following cycle.
- rx_data, rx_perr and rx_ferr are stable while rx_valid & !rx_ready.
- rst asserted mid-frame discards the partial frame. After release the block waits for a fresh falling edge; a line already low does not count.
- Tolerated baud mismatch is at least ±3% at 8N1.

## Structure
- Shared package uart_pkg:
  - parity encodings PAR_NONE, PAR_ODD, PAR_EVEN;
  - FSM state enum;
  - function computing DIV from CLK_FREQ/UART_BPS.
- Sub-module uart_rx_fifo: parameterised width and depth, show-ahead, full and empty outputs. Instantiated with width DATA_BITS+2.
- Elaboration-time checks reject DATA_BITS outside 5..9, STOP_BITS outside {1,2}, PARITY>2, and DIV<2.

## Test plan
- Defaults (8N1, DIV=27), send 0xA5 with rx_ready=1: one rx_valid pulse, rx_data=0xA5, perr=0, ferr=0.
- PARITY=2, send 0x03 with parity bit 1: rx_data=0x03 with rx_perr=1. Repeat with parity bit 0: rx_perr=0.
- 0x5A sent with stop bit forced 0: rx_data=0x5A, rx_ferr=1. Then a 100-cycle low glitch on an idle line: no output, FSM back in IDLE.
- Line held low for 2 frame times: single rx_break pulse, no FIFO write. Next frame 0x11 is received correctly after the line returns high.
- FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05: FIFO holds 0x01..0x04 and rx_overrun=1. Then raise rx_ready: pops return 0x01, 0x02, 0x03, 0x04 in order.
- rst pulsed during data bit 4 of a frame: no output from that frame, all outputs at reset values, next frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - parity mode encodings used by the PARITY parameter
//   - receiver FSM state enumeration
//   - calc_div(): clocks per 16x oversample tick, truncated
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic int calc_div(input int clk_freq, input int bps);
        return clk_freq / (bps * 16);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small show-ahead FIFO.
//   clk, rst          clock, asynchronous active-high reset (empties the FIFO)
//   wr_en, wr_data    push request; ignored when full unless a pop happens in the same cycle
//   rd_en             pop request; ignored when empty
//   rd_data           head entry, read combinationally from storage (zero while empty)
//   full, empty       occupancy flags
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr_reg;
    logic [ADDR_W:0]  rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);

    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage is not reset; gating keeps the head output at zero while empty.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[ADDR_W-1:0]];

endmodule

// File: rtl/uart_rx_multi.sv
// uart_rx_multi: parametrised UART receiver with 16x oversampling and receive FIFO.
//   clk_50m      system clock
//   rst          asynchronous active-high reset
//   uart_rxd     serial input (asynchronous, idle high)
//   rx_data      head word of the receive FIFO
//   rx_perr      parity error flag stored with the head word
//   rx_ferr      framing error flag stored with the head word
//   rx_valid     FIFO non-empty
//   rx_ready     consumer accepts the head word when rx_valid & rx_ready
//   rx_break     one-cycle pulse when a break is detected
//   rx_overrun   sticky, set when a frame is dropped on a full FIFO
module uart_rx_multi
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_break,
    output logic                 rx_overrun
);

    localparam int DIV    = calc_div(CLK_FREQ, UART_BPS);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WORD_W = DATA_BITS + 2;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx_multi: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_rx_multi: STOP_BITS must be 1 or 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_multi: PARITY must be 0, 1 or 2");
        end
        if (DIV < 2) begin : g_bad_div
            $error("uart_rx_multi: CLK_FREQ/(UART_BPS*16) must be at least 2");
        end
    endgenerate

    // ---------------- input synchroniser and edge detect ----------------
    // All stages reset high so reset itself never looks like a start edge.
    logic       rxd_meta_reg;
    logic       rxd_sync_reg;
    logic       rxd_prev_reg;
    logic [1:0] warm_cnt_reg;
    logic       fall_edge;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rxd_meta_reg <= 1'b1;
            rxd_sync_reg <= 1'b1;
            rxd_prev_reg <= 1'b1;
            warm_cnt_reg <= 2'd0;
        end else begin
            rxd_meta_reg <= uart_rxd;
            rxd_sync_reg <= rxd_meta_reg;
            rxd_prev_reg <= rxd_sync_reg;
            if (warm_cnt_reg != 2'd3) begin
                warm_cnt_reg <= warm_cnt_reg + 2'd1;
            end
        end
    end

    // Edges only count once rxd_prev_reg holds a real pin sample, so a line
    // that is already low when reset releases does not start a frame.
    assign fall_edge = (warm_cnt_reg == 2'd3) && rxd_prev_reg && !rxd_sync_reg;

    // ---------------- oversample tick and bit timing ----------------
    rx_state_t            state_reg;
    rx_state_t            state_next;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [3:0]           smp_cnt_reg;
    logic                 vote7_reg;
    logic                 vote8_reg;
    logic                 tick;
    logic                 start_det;
    logic                 bit_dec;
    logic                 bit_val;

    assign tick      = (div_cnt_reg == DIV_W'(DIV - 1));
    assign start_det = (state_reg == ST_IDLE) && fall_edge;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            smp_cnt_reg <= 4'd0;
            vote7_reg   <= 1'b1;
            vote8_reg   <= 1'b1;
        end else if (start_det) begin
            div_cnt_reg <= '0;
            smp_cnt_reg <= 4'd0;
        end else begin
            if (tick) begin
                div_cnt_reg <= '0;
                // 4-bit counter wraps every 16 ticks, i.e. once per bit
                smp_cnt_reg <= smp_cnt_reg + 4'd1;
                if (smp_cnt_reg == 4'd7) begin
                    vote7_reg <= rxd_sync_reg;
                end
                if (smp_cnt_reg == 4'd8) begin
                    vote8_reg <= rxd_sync_reg;
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
        end
    end

    // Bit decision on sample 9, majority of samples 7, 8 and 9.
    assign bit_dec = tick && (smp_cnt_reg == 4'd9);
    assign bit_val = (vote7_reg & vote8_reg) | (vote7_reg & rxd_sync_reg) |
                     (vote8_reg & rxd_sync_reg);

    // ---------------- frame datapath ----------------
    logic [DATA_BITS-1:0] shift_reg;
    logic [3:0]           data_cnt_reg;
    logic                 stop_cnt_reg;
    logic                 perr_reg;
    logic                 ferr_reg;
    logic                 last_data;
    logic                 last_stop;
    logic                 break_cond;
    logic                 par_err;

    assign last_data  = (data_cnt_reg == 4'(DATA_BITS - 1));
    assign last_stop  = (stop_cnt_reg == 1'(STOP_BITS - 1));
    assign break_cond = !stop_cnt_reg && !bit_val && (shift_reg == '0);
    // XOR over data plus parity bit: odd parity wants 1, even wants 0.
    assign par_err    = (PARITY == PAR_ODD) ? ~(^shift_reg ^ bit_val)
                                            :  (^shift_reg ^ bit_val);

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            data_cnt_reg <= 4'd0;
            stop_cnt_reg <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fall_edge) begin
                        data_cnt_reg <= 4'd0;
                        stop_cnt_reg <= 1'b0;
                        perr_reg     <= 1'b0;
                        ferr_reg     <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bit_dec) begin
                        shift_reg    <= {bit_val, shift_reg[DATA_BITS-1:1]};
                        data_cnt_reg <= data_cnt_reg + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (bit_dec) begin
                        perr_reg <= par_err;
                    end
                end
                ST_STOP: begin
                    if (bit_dec) begin
                        if (!bit_val) begin
                            ferr_reg <= 1'b1;
                        end
                        stop_cnt_reg <= stop_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_dec) begin
                    state_next = bit_val ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_dec && last_data) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_dec) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_dec) begin
                    if (break_cond) begin
                        state_next = ST_BREAK;
                    end else if (last_stop) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rxd_sync_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    logic commit;
    logic brk_det;

    always_comb begin
        commit  = 1'b0;
        brk_det = 1'b0;
        if (state_reg == ST_STOP && bit_dec) begin
            if (break_cond) begin
                brk_det = 1'b1;
            end else if (last_stop) begin
                commit = 1'b1;
            end
        end
    end

    // ---------------- commit, FIFO and status ----------------
    logic              push_reg;
    logic [WORD_W-1:0] push_word_reg;
    logic              rx_break_reg;
    logic              rx_overrun_reg;
    logic [WORD_W-1:0] head_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            push_reg       <= 1'b0;
            push_word_reg  <= '0;
            rx_break_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
        end else begin
            push_reg     <= commit;
            rx_break_reg <= brk_det;
            if (commit) begin
                // the current stop decision is not yet folded into ferr_reg
                push_word_reg <= {ferr_reg | ~bit_val, perr_reg, shift_reg};
            end
            if (push_reg && fifo_full && !pop) begin
                rx_overrun_reg <= 1'b1;
            end
        end
    end

    assign pop = rx_valid && rx_ready;

    uart_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_50m),
        .rst     (rst),
        .wr_en   (push_reg),
        .wr_data (push_word_reg),
        .rd_en   (pop),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rx_valid   = !fifo_empty;
    assign rx_data    = head_word[DATA_BITS-1:0];
    assign rx_perr    = head_word[DATA_BITS];
    assign rx_ferr    = head_word[DATA_BITS+1];
    assign rx_break   = rx_break_reg;
    assign rx_overrun = rx_overrun_reg;

endmodule

// File: tb/tb_uart_rx_multi.sv
// tb_uart_rx_multi: two receivers share clock and reset.
//   dut_a: defaults, 8N1 at 115200 baud (27 clocks per tick, 432 per bit)
//   dut_b: 8 data bits, even parity, 2 stop bits at 1 Mbaud (3 clocks per tick, 48 per bit)
// Words are packed {ferr, perr, data} for comparison.
`timescale 1ns/1ps
module tb_uart_rx_multi;

    localparam int BIT_A = 432;
    localparam int BIT_B = 48;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       rxd_a, rxd_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       perr_a, perr_b, ferr_a, ferr_b;
    logic       valid_a, valid_b, brk_a, brk_b, ovr_a, ovr_b;

    always #10 clk_50m = ~clk_50m;

    uart_rx_multi #(
        .CLK_FREQ(50000000), .UART_BPS(115200), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk_50m(clk_50m), .rst(rst), .uart_rxd(rxd_a),
        .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a),
        .rx_valid(valid_a), .rx_ready(ready_a),
        .rx_break(brk_a), .rx_overrun(ovr_a)
    );

    uart_rx_multi #(
        .CLK_FREQ(50000000), .UART_BPS(1000000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk_50m(clk_50m), .rst(rst), .uart_rxd(rxd_b),
        .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b),
        .rx_valid(valid_b), .rx_ready(ready_b),
        .rx_break(brk_b), .rx_overrun(ovr_b)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] got_a[$];
    logic [9:0] got_b[$];
    int         brk_cnt_a = 0;
    int         brk_cnt_b = 0;

    // Consumer side monitors: every accepted word and every break cycle.
    always @(negedge clk_50m) begin
        if (valid_a && ready_a) got_a.push_back({ferr_a, perr_a, data_a});
        if (valid_b && ready_b) got_b.push_back({ferr_b, perr_b, data_b});
        if (brk_a) brk_cnt_a++;
        if (brk_b) brk_cnt_b++;
    end

    // Serial frame as a bit vector, LSB first, starting with the start bit.
    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
        logic [15:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        b[9]   = stop;
        return b;   // 11 bits used: start, 8 data, stop, one idle bit
    endfunction

    function automatic logic [15:0] frame_b(input logic [7:0] d, input logic p,
                                            input logic s1, input logic s2);
        logic [15:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        b[9]   = p;
        b[10]  = s1;
        b[11]  = s2;
        return b;   // 13 bits used: start, 8 data, parity, 2 stop, one idle bit
    endfunction

    task automatic send_frame(input int sel, input logic [15:0] bits,
                              input int n, input int bit_cyc);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rxd_a = bits[i];
            else          rxd_b = bits[i];
            repeat (bit_cyc) @(negedge clk_50m);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rxd_a = 1'b1; rxd_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1;
        repeat (5) @(negedge clk_50m);
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_a); end
        checks++; if (perr_a !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", perr_a); end
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ferr_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        checks++; if (brk_a !== 1'b0) begin errors++; $display("FAIL reset_break: got %b expected 0", brk_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr_a); end
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b expected 0", valid_b); end
        rst = 1'b0;
        repeat (10) @(negedge clk_50m);
        $display("reset: outputs checked");
    endtask

    task automatic test_basic;
        int n0;
        n0 = got_a.size();
        send_frame(0, frame_a(8'hA5, 1'b1), 11, BIT_A);
        checks++;
        if (got_a.size() != n0 + 1) begin
            errors++; $display("FAIL basic_count: got %0d words expected 1", got_a.size() - n0);
        end else begin
            checks++;
            if (got_a[n0] !== 10'h0A5) begin errors++; $display("FAIL basic_word: got %h expected 0a5", got_a[n0]); end
        end
        $display("basic: sent a5");
    endtask

    task automatic test_parity;
        logic [7:0] d;
        logic       p, s1, s2, exp_brk;
        logic [9:0] exp_word;
        int         n0, b0;
        for (int k = 0; k < 10; k++) begin
            if (k < 2) begin
                d = 8'h03; p = (k == 0); s1 = 1'b1; s2 = 1'b1;
            end else begin
                d  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                p  = 1'($urandom_range(0, 1));
                s1 = ($urandom_range(0, 3) != 0);
                s2 = ($urandom_range(0, 3) != 0);
            end
            // Even parity: data XOR parity must be 0. Break = zero data and first stop low.
            exp_brk  = (d == 8'h00) && !s1;
            exp_word = {~(s1 & s2), ^d ^ p, d};
            n0 = got_b.size();
            b0 = brk_cnt_b;
            send_frame(1, frame_b(d, p, s1, s2), 13, BIT_B);
            repeat (2 * BIT_B) @(negedge clk_50m);
            checks++;
            if ((brk_cnt_b - b0) != (exp_brk ? 1 : 0)) begin
                errors++; $display("FAIL parity_break[%0d]: got %0d pulses expected %0d", k, brk_cnt_b - b0, exp_brk);
            end
            checks++;
            if (got_b.size() != n0 + (exp_brk ? 0 : 1)) begin
                errors++; $display("FAIL parity_count[%0d]: got %0d words expected %0d", k, got_b.size() - n0, !exp_brk);
            end else if (!exp_brk) begin
                checks++;
                if (got_b[n0] !== exp_word) begin
                    errors++; $display("FAIL parity_word[%0d]: got %h expected %h", k, got_b[n0], exp_word);
                end
            end
            $display("parity: d=%h p=%b s=%b%b break=%b", d, p, s1, s2, exp_brk);
        end
    endtask

    task automatic test_framing_glitch;
        int n0, b0;
        n0 = got_a.size();
        send_frame(0, frame_a(8'h5A, 1'b0), 11, BIT_A);
        checks++;
        if (got_a.size() != n0 + 1) begin
            errors++; $display("FAIL ferr_count: got %0d words expected 1", got_a.size() - n0);
        end else begin
            checks++;
            if (got_a[n0] !== 10'h25A) begin errors++; $display("FAIL ferr_word: got %h expected 25a", got_a[n0]); end
        end
        $display("framing: sent 5a with stop 0");
        n0 = got_a.size();
        b0 = brk_cnt_a;
        rxd_a = 1'b0;
        repeat (100) @(negedge clk_50m);
        rxd_a = 1'b1;
        repeat (12 * BIT_A) @(negedge clk_50m);
        checks++;
        if (got_a.size() != n0 || brk_cnt_a != b0) begin
            errors++; $display("FAIL glitch: got %0d words %0d breaks expected 0 0", got_a.size() - n0, brk_cnt_a - b0);
        end
        $display("glitch: 100-cycle low pulse");
    endtask

    task automatic test_break;
        int n0, b0;
        n0 = got_a.size();
        b0 = brk_cnt_a;
        rxd_a = 1'b0;
        repeat (20 * BIT_A) @(negedge clk_50m);
        rxd_a = 1'b1;
        repeat (2 * BIT_A) @(negedge clk_50m);
        checks++;
        if (brk_cnt_a - b0 != 1) begin errors++; $display("FAIL break_pulse: got %0d cycles expected 1", brk_cnt_a - b0); end
        checks++;
        if (got_a.size() != n0) begin errors++; $display("FAIL break_nowrite: got %0d words expected 0", got_a.size() - n0); end
        $display("break: line low for 2 frames");
        n0 = got_a.size();
        send_frame(0, frame_a(8'h11, 1'b1), 11, BIT_A);
        checks++;
        if (got_a.size() != n0 + 1) begin
            errors++; $display("FAIL after_break_count: got %0d words expected 1", got_a.size() - n0);
        end else begin
            checks++;
            if (got_a[n0] !== 10'h011) begin errors++; $display("FAIL after_break_word: got %h expected 011", got_a[n0]); end
        end
        $display("break: sent 11 afterwards");
    endtask

    task automatic test_overrun;
        logic [9:0] model_q[$];
        logic       exp_ovr;
        int         n0;
        exp_ovr = 1'b0;
        ready_a = 1'b0;
        n0 = got_a.size();
        for (int k = 1; k <= 5; k++) begin
            if (model_q.size() < 4) model_q.push_back(10'(k));
            else                    exp_ovr = 1'b1;
            send_frame(0, frame_a(8'(k), 1'b1), 11, BIT_A);
            $display("overrun: sent %02h with rx_ready low", k);
        end
        checks++; if (ovr_a !== exp_ovr) begin errors++; $display("FAIL overrun_flag: got %b expected %b", ovr_a, exp_ovr); end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", valid_a); end
        checks++; if (data_a !== model_q[0][7:0]) begin errors++; $display("FAIL overrun_head: got %h expected %h", data_a, model_q[0][7:0]); end
        ready_a = 1'b1;
        repeat (10) @(negedge clk_50m);
        checks++;
        if (got_a.size() != n0 + model_q.size()) begin
            errors++; $display("FAIL drain_count: got %0d words expected %0d", got_a.size() - n0, model_q.size());
        end else begin
            for (int k = 0; k < model_q.size(); k++) begin
                checks++;
                if (got_a[n0 + k] !== model_q[k]) begin
                    errors++; $display("FAIL drain_word[%0d]: got %h expected %h", k, got_a[n0 + k], model_q[k]);
                end
            end
        end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", valid_a); end
        $display("overrun: drained fifo");
    endtask

    task automatic test_reset_midframe;
        logic [15:0] bits;
        int          n0, b0;
        // 0xC5: bits 4 and 5 are low, so the line is still low when reset releases.
        bits = frame_a(8'hC5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rxd_a = bits[i];
            repeat (BIT_A) @(negedge clk_50m);
        end
        rxd_a = bits[5];
        repeat (BIT_A / 2) @(negedge clk_50m);
        rst = 1'b1;
        repeat (3) @(negedge clk_50m);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", valid_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b expected 0", ovr_a); end
        checks++; if ({ferr_a, perr_a, data_a} !== 10'h000) begin errors++; $display("FAIL midrst_word: got %h expected 000", {ferr_a, perr_a, data_a}); end
        rst = 1'b0;
        n0 = got_a.size();
        b0 = brk_cnt_a;
        repeat (BIT_A / 2) @(negedge clk_50m);
        for (int i = 6; i < 11; i++) begin
            rxd_a = bits[i];
            repeat (BIT_A) @(negedge clk_50m);
        end
        repeat (6 * BIT_A) @(negedge clk_50m);
        checks++;
        if (got_a.size() != n0 || brk_cnt_a != b0) begin
            errors++; $display("FAIL midrst_discard: got %0d words %0d breaks expected 0 0", got_a.size() - n0, brk_cnt_a - b0);
        end
        $display("reset_midframe: rst during data bit 4");
        n0 = got_a.size();
        send_frame(0, frame_a(8'h3C, 1'b1), 11, BIT_A);
        checks++;
        if (got_a.size() != n0 + 1) begin
            errors++; $display("FAIL midrst_next_count: got %0d words expected 1", got_a.size() - n0);
        end else begin
            checks++;
            if (got_a[n0] !== 10'h03C) begin errors++; $display("FAIL midrst_next_word: got %h expected 03c", got_a[n0]); end
        end
        $display("reset_midframe: sent 3c afterwards");
    endtask

    task automatic test_baud_tolerance;
        logic [7:0] d;
        int         cyc, n0;
        for (int k = 0; k < 2; k++) begin
            cyc = (k == 0) ? 419 : 445;   // about -3% and +3% bit period
            d   = 8'($urandom_range(1, 255));
            n0  = got_a.size();
            send_frame(0, frame_a(d, 1'b1), 11, cyc);
            checks++;
            if (got_a.size() != n0 + 1) begin
                errors++; $display("FAIL baud_count[%0d]: got %0d words expected 1", k, got_a.size() - n0);
            end else begin
                checks++;
                if (got_a[n0] !== {2'b00, d}) begin
                    errors++; $display("FAIL baud_word[%0d]: got %h expected %h", k, got_a[n0], {2'b00, d});
                end
            end
            $display("baud: sent %h at %0d clocks per bit", d, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing_glitch();
        test_break();
        test_overrun();
        test_reset_midframe();
        test_baud_tolerance();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
